// File: rtl/i2c_byte_master.sv
// Command-level I2C master: executes one START, STOP, WRITE-byte or READ-byte per strobe,
// driving SCL/SDA through open-drain output enables.
module i2c_byte_master #(
  parameter int DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  input  logic [1:0] cmd,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  input  logic       stb,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_e;

  localparam logic [DW-1:0] PRESC_MAX = '1;
  localparam logic [DW-1:0] PRESC_ONE = DW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] presc_q, presc_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    slot_q, slot_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          ack_in_q, ack_in_d;
  logic          ack_out_q, ack_out_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          ready_q, ready_d;
  logic          load_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      phase_q    <= '0;
      slot_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      ack_in_q   <= 1'b0;
      ack_out_q  <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      ack_in_q   <= ack_in_d;
      ack_out_q  <= ack_out_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    ack_in_d   = ack_in_q;
    ack_out_d  = ack_out_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    load_out   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (stb) begin
          case (cmd)
            2'b00:   state_d = ST_START;
            2'b01:   state_d = ST_STOP;
            2'b10:   state_d = ST_WRITE;
            default: state_d = ST_READ;
          endcase
          presc_d  = '0;
          phase_d  = 2'd0;
          slot_d   = 4'd0;
          tx_d     = data_in;
          ack_in_d = ack_in;
          load_out = 1'b1;
        end
      end
      default: begin
        presc_d = presc_q + PRESC_ONE;
        if (presc_q == PRESC_MAX) begin
          // Last clk of ph2 is the end of the SCL-high window: sample SDA here.
          if (phase_q == 2'd2) begin
            if (state_q == ST_READ && slot_q < 4'd8) begin
              rx_d = {rx_q[6:0], sda_i};
              if (slot_q == 4'd7) data_out_d = {rx_q[6:0], sda_i};
            end
            if (state_q == ST_WRITE && slot_q == 4'd8) ack_out_d = sda_i;
          end
          if (phase_q == 2'd3) begin
            if (state_q == ST_START || state_q == ST_STOP || slot_q == 4'd8) begin
              // Outputs keep the final phase value while idle.
              state_d = ST_IDLE;
              presc_d = '0;
              phase_d = 2'd0;
            end else begin
              slot_d   = slot_q + 4'd1;
              phase_d  = 2'd0;
              tx_d     = {tx_q[6:0], 1'b0};
              load_out = 1'b1;
            end
          end else begin
            phase_d  = phase_q + 2'd1;
            load_out = 1'b1;
          end
        end
      end
    endcase

    ready_d = (state_d == ST_IDLE);

    if (load_out) begin
      case (state_d)
        ST_START: begin
          case (phase_d)
            2'd0:    {scl_oe_d, sda_oe_d} = 2'b10;
            2'd1:    {scl_oe_d, sda_oe_d} = 2'b00;
            2'd2:    {scl_oe_d, sda_oe_d} = 2'b01;
            default: {scl_oe_d, sda_oe_d} = 2'b11;
          endcase
        end
        ST_STOP: begin
          case (phase_d)
            2'd0:    {scl_oe_d, sda_oe_d} = 2'b11;
            2'd1:    {scl_oe_d, sda_oe_d} = 2'b01;
            default: {scl_oe_d, sda_oe_d} = 2'b00;
          endcase
        end
        ST_WRITE: begin
          scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
          sda_oe_d = (slot_d == 4'd8) ? 1'b0 : ~tx_d[7];
        end
        ST_READ: begin
          scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
          sda_oe_d = (slot_d == 4'd8) ? ~ack_in_d : 1'b0;
        end
        default: begin
          scl_oe_d = scl_oe_q;
          sda_oe_d = sda_oe_q;
        end
      endcase
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign data_out = data_out_q;
  assign ack_out  = ack_out_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: per-phase oe scoreboard plus byte/ack result queue.
module tb_i2c_byte_master;

  localparam int DW = 4;
  localparam int PH = 2 ** DW;

  logic       clk;
  logic       rst;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;
  logic [1:0] cmd;
  logic [7:0] data_in;
  logic       ack_in;
  logic       stb;
  logic [7:0] data_out;
  logic       ack_out;
  logic       ready;

  logic [1:0] exp_q[$];
  logic [8:0] res_q[$];
  logic [7:0] exp_data;
  logic       exp_ack;
  int         checks;
  int         errors;

  i2c_byte_master #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i),
    .cmd      (cmd),
    .data_in  (data_in),
    .ack_in   (ack_in),
    .stb      (stb),
    .data_out (data_out),
    .ack_out  (ack_out),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference (scl_oe, sda_oe) for phase p of a command.
  function automatic logic [1:0] phase_val(input logic [1:0] c, input logic [7:0] d,
                                           input logic a, input int p);
    int slot;
    int ph;
    logic scl;
    logic sda;
    slot = p / 4;
    ph   = p % 4;
    if (c == 2'b00) begin
      case (ph)
        0:       return 2'b10;
        1:       return 2'b00;
        2:       return 2'b01;
        default: return 2'b11;
      endcase
    end
    if (c == 2'b01) begin
      case (ph)
        0:       return 2'b11;
        1:       return 2'b01;
        default: return 2'b00;
      endcase
    end
    scl = (ph == 0) || (ph == 3);
    if (c == 2'b10) sda = (slot < 8) ? ~d[7 - slot] : 1'b0;
    else            sda = (slot < 8) ? 1'b0 : ~a;
    return {scl, sda};
  endfunction

  // bits[8-s] is driven on sda_i during slot s (s = 0..8).
  task automatic run_cmd(input string name, input logic [1:0] c, input logic [7:0] d,
                         input logic a, input logic [8:0] bits, input bit poke);
    int nph;
    logic [1:0] pv;
    logic [8:0] res;
    nph = c[1] ? 36 : 4;
    for (int p = 0; p < nph; p++) exp_q.push_back(phase_val(c, d, a, p));
    if (c == 2'b10) exp_ack = bits[0];
    if (c == 2'b11) exp_data = bits[8:1];
    res_q.push_back({exp_ack, exp_data});

    @(negedge clk);
    cmd = c; data_in = d; ack_in = a; stb = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    data_in = 8'($urandom_range(0, 255));
    ack_in = 1'($urandom_range(0, 1));
    pv = 2'b00;
    for (int p = 0; p < nph; p++) begin
      pv = exp_q.pop_front();
      for (int cyc = 0; cyc < PH; cyc++) begin
        @(negedge clk);
        stb = 1'b0;
        if (c[1] && cyc == 0 && (p % 4) == 0) sda_i = bits[8 - p / 4];
        if (poke && p == 10 && cyc == 3) begin
          cmd = 2'($urandom_range(0, 3));
          data_in = 8'($urandom_range(0, 255));
          stb = 1'b1;
        end
        if (cyc == 0 || cyc == PH - 1) begin
          check_eq({name, "_oe"}, {30'd0, scl_oe, sda_oe}, {30'd0, pv});
          check_eq({name, "_busy"}, {31'd0, ready}, 32'd0);
        end
      end
    end
    @(negedge clk);
    sda_i = 1'b1;
    check_eq({name, "_ready"}, {31'd0, ready}, 32'd1);
    check_eq({name, "_hold_oe"}, {30'd0, scl_oe, sda_oe}, {30'd0, pv});
    res = res_q.pop_front();
    check_eq({name, "_data_out"}, {24'd0, data_out}, {24'd0, res[7:0]});
    check_eq({name, "_ack_out"}, {31'd0, ack_out}, {31'd0, res[8]});
  endtask

  initial begin
    logic [7:0] rnd;
    checks = 0; errors = 0;
    exp_data = 8'h00; exp_ack = 1'b0;
    rst = 1'b1; stb = 1'b0; cmd = 2'b00; data_in = 8'h00; ack_in = 1'b1; sda_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_scl", {31'd0, scl_oe}, 32'd0);
    check_eq("rst_sda", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_data", {24'd0, data_out}, 32'd0);
    check_eq("rst_ack", {31'd0, ack_out}, 32'd0);

    run_cmd("start", 2'b00, 8'h00, 1'b1, 9'h1FF, 1'b0);
    run_cmd("wr14", 2'b10, 8'h14, 1'b1, 9'h000, 1'b0);
    run_cmd("wrff", 2'b10, 8'hFF, 1'b1, 9'h1FF, 1'b1);
    run_cmd("rda5", 2'b11, 8'h00, 1'b1, {8'hA5, 1'b1}, 1'b0);
    run_cmd("stop", 2'b01, 8'h00, 1'b0, 9'h1FF, 1'b0);
    run_cmd("start2", 2'b00, 8'h00, 1'b0, 9'h1FF, 1'b0);
    rnd = 8'($urandom_range(0, 255));
    run_cmd("rd_ack", 2'b11, 8'h00, 1'b0, {rnd, 1'b1}, 1'b1);
    run_cmd("restart", 2'b00, 8'h00, 1'b0, 9'h1FF, 1'b0);
    rnd = 8'($urandom_range(0, 255));
    run_cmd("wr_rnd", 2'b10, rnd, 1'b0, {8'h00, 1'($urandom_range(0, 1))}, 1'b0);

    // Abort a READ partway through with a reset.
    @(negedge clk);
    cmd = 2'b11; ack_in = 1'b0; stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    repeat (100) @(negedge clk);
    sda_i = 1'b0;
    check_eq("abort_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    check_eq("abort_data", {24'd0, data_out}, 32'd0);
    check_eq("abort_ack", {31'd0, ack_out}, 32'd0);
    sda_i = 1'b1;
    exp_data = 8'h00; exp_ack = 1'b0;

    run_cmd("post_start", 2'b00, 8'h00, 1'b1, 9'h1FF, 1'b0);
    run_cmd("post_stop", 2'b01, 8'h00, 1'b1, 9'h1FF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
